pb_event_decoder: RTL
=====================

// Module: pb_event_decoder
// PURPOSE
//   Consumer of a debounced push-button level. Converts the clean level into
//   one-cycle event pulses: press, release, click (short press), long-press and
//   auto-repeat while held. Sits between the per-button debouncer and the
//   control logic (counters, menus, display mode).
// PARAMETERS
//   LONG_CYCLES    50_000_000  cycles held before long_pulse (0.5 s @ 100 MHz); >=1
//   REPEAT_PERIOD  10_000_000  cycles between repeat_pulse after long press; >=1
//   REPEAT_EN      1           1: auto-repeat enabled; 0: repeat_pulse never asserts
//   CNT_W          26          counter width; 2**CNT_W > max(LONG_CYCLES,REPEAT_PERIOD)-1
// PORTS
//   clk            in   1  system clock; all logic on posedge
//   rst_n          in   1  asynchronous, active-low reset
//   pb_level       in   1  debounced button level, synchronous to clk; 1 = pressed
//   press_pulse    out  1  one cycle high on press
//   release_pulse  out  1  one cycle high on release
//   click_pulse    out  1  one cycle high on release before long threshold
//   long_pulse     out  1  one cycle high when hold reaches LONG_CYCLES
//   repeat_pulse   out  1  one cycle high every REPEAT_PERIOD after long_pulse
//   held           out  1  high while state is PRESSED or REPEAT
// BEHAVIOUR
//   - All outputs registered. Reset: state=WAIT_REL, cnt=0, every output 0.
//   - States: WAIT_REL, IDLE, PRESSED, REPEAT. Edge k = posedge sampling pb_level.
//   - WAIT_REL: pb_level=0 -> IDLE; else stay. No events. Button held through
//     reset (or reset mid-press) produces no press/release until released.
//   - IDLE: pb_level=1 -> PRESSED, cnt<=0, press_pulse<=1 (high k..k+1).
//   - PRESSED, pb_level=0 -> IDLE, release_pulse<=1, click_pulse<=1.
//   - PRESSED, pb_level=1: cnt==LONG_CYCLES-1 -> REPEAT, cnt<=0, long_pulse<=1;
//     else cnt<=cnt+1. long_pulse fires at edge press+LONG_CYCLES.
//   - REPEAT, pb_level=0 -> IDLE, release_pulse<=1, no click_pulse.
//   - REPEAT, pb_level=1: cnt==REPEAT_PERIOD-1 -> cnt<=0, repeat_pulse<=REPEAT_EN;
//     else cnt<=cnt+1. First repeat at edge long+REPEAT_PERIOD, then periodic.
//   - Release takes priority over threshold on the same edge: no long/repeat
//     pulse when pb_level=0 at the threshold edge.
//   - Pulses default to 0 each cycle; at most one of press/release/long/repeat
//     high in any cycle (click coincides with release only).
//   - cnt never wraps: cleared at threshold, on state exit and on reset.
//   - held registered: 1 the cycle after entering PRESSED, 0 after exit to IDLE.
//   - Minimum press (1 cycle high): press_pulse, then release_pulse+click_pulse
//     on next edge; back-to-back presses with 1-cycle gap each produce events.
// TESTING  (bench overrides LONG_CYCLES=8, REPEAT_PERIOD=4, CNT_W=4)
//   1 pb_level=1 during/after reset, low at cycle 20 -> no pulses at all;
//     next press at cycle 30 -> press_pulse cycle 31 only.
//   2 press 3 cycles then release -> press_pulse once, release_pulse and
//     click_pulse together 3 cycles later, no long_pulse, held high 3 cycles.
//   3 hold 20 cycles -> long_pulse 8 cycles after press_pulse, repeat_pulse
//     at +4 and +8 after long_pulse; release -> release_pulse, no click_pulse.
//   4 release exactly on threshold edge (held 7 cycles, low at edge 8) ->
//     click_pulse+release_pulse, long_pulse never asserts.
//   5 REPEAT_EN=0, hold 30 cycles -> single long_pulse, repeat_pulse stays 0.
//   6 rst_n low mid-REPEAT for 2 cycles, button still held -> outputs 0
//     immediately (async), no events until release and a fresh press.

Source files
------------

// File: rtl/pb_event_decoder.sv
// Turns a debounced push-button level into one-cycle press/release/click/long/repeat
// event pulses plus a registered "held" status.
module pb_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned CNT_W         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2,
    REPEAT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_REL;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  // Release is tested before the threshold so a release on the threshold edge
  // suppresses the long/repeat pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      WAIT_REL: begin
        cnt_d = '0;
        if (!pb_level) state_d = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (pb_level) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!pb_level) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!pb_level) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = REPEAT_EN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == PRESSED) || (state_d == REPEAT);
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule
